// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the MiniUart bus controller: register map, STATUS/IER
// bit positions, transmit sequencer states and the reset baud divisor.
package uart_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_IER    = 2'd2;
  localparam logic [1:0] ADDR_DIV    = 2'd3;

  localparam int unsigned ST_RX_AVAIL = 0;
  localparam int unsigned ST_TX_IDLE  = 1;
  localparam int unsigned ST_OVR      = 2;
  localparam int unsigned ST_TX_DONE  = 3;
  localparam int unsigned ST_THR_FULL = 4;

  localparam int unsigned IE_RX  = 0;
  localparam int unsigned IE_TXD = 1;
  localparam int unsigned IE_OVR = 2;

  // 25 MHz / (9600 * 8)
  localparam logic [15:0] DIV_INIT = 16'd325;

  typedef enum logic [1:0] {
    T_IDLE,
    T_LOAD,
    T_ACK,
    T_BUSY
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: en_rx pulses once every max(div,1) clocks (8x baud) and en_tx
// on every eighth en_rx (1x baud). clr restarts both counters.
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             clr,
  output logic             en_rx,
  output logic             en_tx
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] last;
  logic [2:0]       sub_q, sub_d;

  always_comb begin
    // div of 0 and 1 both collapse to a terminal count of 0: pulse every cycle
    last  = (div > DIV_W'(1)) ? div - DIV_W'(1) : '0;
    en_rx = (cnt_q == last);
    en_tx = en_rx & (sub_q == 3'd7);
    cnt_d = en_rx ? '0 : cnt_q + DIV_W'(1);
    sub_d = en_rx ? sub_q + 3'd1 : sub_q;
    if (clr) begin
      cnt_d = '0;
      sub_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sub_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sub_q <= sub_d;
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// MiniUart bus controller: 4-word register window, receive holding register
// with overrun detection, transmit load sequencer and a registered interrupt.
module uart_ctrl #(
  parameter int unsigned      DIV_W    = 16,
  parameter logic [DIV_W-1:0] DIV_INIT = DIV_W'(uart_ctrl_pkg::DIV_INIT)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        en_rx,
  output logic        en_tx,
  input  logic [7:0]  rx_byte,
  input  logic        rx_rs,
  output logic        over_read,
  output logic [7:0]  tx_data,
  output logic        tx_load,
  input  logic        tx_busy
);

  import uart_ctrl_pkg::*;

  logic rd_data, wr_data, rd_status, wr_ier, wr_div;

  logic [2:0]       rx_sync_q, rx_sync_d;
  logic             rx_rise;
  logic [7:0]       rhr_q, rhr_d;
  logic             rx_avail_q, rx_avail_d;
  logic             ovr_q, ovr_d;
  logic             over_read_q, over_read_d;

  tx_state_e        tx_state_q, tx_state_d;
  logic [7:0]       thr_q, thr_d;
  logic             thr_full_q, thr_full_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_idle;

  logic [2:0]       ier_q, ier_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             irq_q, irq_d;

  logic             unused_wdata;

  assign rd_data   = sel & ~we & (addr == ADDR_DATA);
  assign wr_data   = sel &  we & (addr == ADDR_DATA);
  assign rd_status = sel & ~we & (addr == ADDR_STATUS);
  assign wr_ier    = sel &  we & (addr == ADDR_IER);
  assign wr_div    = sel &  we & (addr == ADDR_DIV);
  assign unused_wdata = ^wdata;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .div   (div_q),
    .clr   (wr_div),
    .en_rx (en_rx),
    .en_tx (en_tx)
  );

  // rx_sync_q[1:0] is the synchronizer, [2] is the edge-detect history
  always_comb begin
    rx_sync_d   = {rx_sync_q[1:0], rx_rs};
    rx_rise     = rx_sync_q[1] & ~rx_sync_q[2];
    rhr_d       = rhr_q;
    rx_avail_d  = rx_avail_q;
    ovr_d       = ovr_q;
    over_read_d = rx_rise;
    if (rd_data)   rx_avail_d = 1'b0;
    if (rd_status) ovr_d      = 1'b0;
    // A capture overrides a same-cycle DATA read; that read consumed the old byte
    if (rx_rise) begin
      rhr_d      = rx_byte;
      rx_avail_d = 1'b1;
      if (rx_avail_q && !rd_data) ovr_d = 1'b1;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    tx_done_d  = tx_done_q;
    tx_load    = 1'b0;
    if (rd_status) tx_done_d = 1'b0;
    if (wr_data && !thr_full_q) begin
      thr_d      = wdata[7:0];
      thr_full_d = 1'b1;
    end
    case (tx_state_q)
      T_IDLE: if (thr_full_q && !tx_busy) tx_state_d = T_LOAD;
      T_LOAD: begin
        tx_load    = 1'b1;
        thr_full_d = 1'b0;
        tx_state_d = T_ACK;
      end
      T_ACK:  if (tx_busy) tx_state_d = T_BUSY;
      T_BUSY: if (!tx_busy) begin
        tx_done_d  = 1'b1;
        tx_state_d = T_IDLE;
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  assign tx_idle   = (tx_state_q == T_IDLE) & ~thr_full_q;
  assign tx_data   = thr_q;
  assign over_read = over_read_q;
  assign irq       = irq_q;

  always_comb begin
    ier_d = wr_ier ? wdata[2:0] : ier_q;
    div_d = wr_div ? wdata[DIV_W-1:0] : div_q;
    irq_d = (rx_avail_q & ier_q[IE_RX]) |
            (tx_done_q  & ier_q[IE_TXD]) |
            (ovr_q      & ier_q[IE_OVR]);
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA:   rdata[7:0] = rhr_q;
      ADDR_STATUS: begin
        rdata[ST_RX_AVAIL] = rx_avail_q;
        rdata[ST_TX_IDLE]  = tx_idle;
        rdata[ST_OVR]      = ovr_q;
        rdata[ST_TX_DONE]  = tx_done_q;
        rdata[ST_THR_FULL] = thr_full_q;
      end
      ADDR_IER:    rdata[2:0] = ier_q;
      ADDR_DIV:    rdata[DIV_W-1:0] = div_q;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_q   <= '0;
      rhr_q       <= '0;
      rx_avail_q  <= 1'b0;
      ovr_q       <= 1'b0;
      over_read_q <= 1'b0;
      tx_state_q  <= T_IDLE;
      thr_q       <= '0;
      thr_full_q  <= 1'b0;
      tx_done_q   <= 1'b0;
      ier_q       <= '0;
      div_q       <= DIV_INIT;
      irq_q       <= 1'b0;
    end else begin
      rx_sync_q   <= rx_sync_d;
      rhr_q       <= rhr_d;
      rx_avail_q  <= rx_avail_d;
      ovr_q       <= ovr_d;
      over_read_q <= over_read_d;
      tx_state_q  <= tx_state_d;
      thr_q       <= thr_d;
      thr_full_q  <= thr_full_d;
      tx_done_q   <= tx_done_d;
      ier_q       <= ier_d;
      div_q       <= div_d;
      irq_q       <= irq_d;
    end
  end

endmodule
